exe_stage: RTL and testbench

// - EXE-stage consumer of the ID/EXE pipeline register outputs: selects operands,

---
 rtl/exe_stage_if.sv | 46 ++++
 rtl/exe_stage.sv | 147 ++++++++++++++
 tb/tb_exe_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_if.sv
// EXE-stage bus: ID/EXE register fields in, EXE/MEM register fields and stall out.
// OVF_DETECT_EN adds the mem_ovf field.
interface exe_stage_if #(
  parameter int DATA_W = 32
);
  logic              exe_wreg;
  logic              exe_m2reg;
  logic              exe_wmem;
  logic [2:0]        exe_aluc;
  logic              exe_aluimm;
  logic [DATA_W-1:0] exe_a;
  logic [DATA_W-1:0] exe_b;
  logic [DATA_W-1:0] exe_imm;
  logic [4:0]        exe_rn;
  logic              exe_shift;
  logic              exe_wz;
  logic              exe_stall;
  logic              mem_wreg;
  logic              mem_m2reg;
  logic              mem_wmem;
  logic [DATA_W-1:0] mem_alu;
  logic [DATA_W-1:0] mem_b;
  logic [4:0]        mem_rn;
  logic              z;
`ifdef OVF_DETECT_EN
  logic              mem_ovf;
`endif

  modport master (
    output exe_wreg, exe_m2reg, exe_wmem, exe_aluc, exe_aluimm,
    output exe_a, exe_b, exe_imm, exe_rn, exe_shift, exe_wz,
    input  exe_stall, mem_wreg, mem_m2reg, mem_wmem, mem_alu, mem_b, mem_rn, z
`ifdef OVF_DETECT_EN
    , input mem_ovf
`endif
  );

  modport slave (
    input  exe_wreg, exe_m2reg, exe_wmem, exe_aluc, exe_aluimm,
    input  exe_a, exe_b, exe_imm, exe_rn, exe_shift, exe_wz,
    output exe_stall, mem_wreg, mem_m2reg, mem_wmem, mem_alu, mem_b, mem_rn, z
`ifdef OVF_DETECT_EN
    , output mem_ovf
`endif
  );
endinterface

// File: rtl/exe_stage.sv
// Pipeline EXE stage: operand select, ALU, iterative shift-add multiply, EXE/MEM register.
// Define OVF_DETECT_EN to flag ADD/SUB signed overflow on mem_ovf and suppress the write.
module exe_stage #(
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         clrn,
  exe_stage_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] op_a, op_b, alu_res, result;
  logic [DATA_W-1:0] mcand, mplier, acc;
  logic [CNT_W-1:0]  cnt;
  logic              is_mul, leave, wreg_ok;

  assign is_mul = (bus.exe_aluc == OP_MUL);
  // The instruction retires into EXE/MEM on this edge; every other edge is a bubble.
  assign leave  = ((state == IDLE) && !is_mul) || (state == DONE);
  assign result = (state == DONE) ? acc : alu_res;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op_a    = bus.exe_shift ? DATA_W'(bus.exe_imm[10:6]) : bus.exe_a;
    op_b    = bus.exe_aluimm ? bus.exe_imm : bus.exe_b;
    alu_res = '0;
    case (bus.exe_aluc)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_b << op_a[4:0];
      OP_SRL:  alu_res = op_b >> op_a[4:0];
      default: alu_res = '0;
    endcase
  end

`ifdef OVF_DETECT_EN
  logic ovf;

  always_comb begin
    ovf = 1'b0;
    if (bus.exe_aluc == OP_ADD)
      ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
    else if (bus.exe_aluc == OP_SUB)
      ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
  end

  assign wreg_ok = ~ovf;
`else
  assign wreg_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!clrn) state <= IDLE;
    else       state <= next_state;
  end

  // Stall stays low in DONE so the held MUL leaves instead of being re-issued.
  always_comb begin
    next_state    = state;
    bus.exe_stall = 1'b0;
    case (state)
      IDLE: if (is_mul) begin
        next_state    = BUSY;
        bus.exe_stall = 1'b1;
      end
      BUSY: begin
        bus.exe_stall = 1'b1;
        if (cnt == '0) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shift-add multiplier: one multiplier bit per BUSY cycle, low DATA_W bits kept.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == IDLE && is_mul) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
      cnt    <= CNT_W'(DATA_W - 1);
    end else if (state == BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bus.mem_wreg  <= 1'b0;
      bus.mem_m2reg <= 1'b0;
      bus.mem_wmem  <= 1'b0;
      bus.mem_alu   <= '0;
      bus.mem_b     <= '0;
      bus.mem_rn    <= '0;
      bus.z         <= 1'b0;
`ifdef OVF_DETECT_EN
      bus.mem_ovf   <= 1'b0;
`endif
    end else if (leave) begin
      bus.mem_wreg  <= bus.exe_wreg & wreg_ok;
      bus.mem_m2reg <= bus.exe_m2reg;
      bus.mem_wmem  <= bus.exe_wmem;
      bus.mem_alu   <= result;
      bus.mem_b     <= bus.exe_b;
      bus.mem_rn    <= bus.exe_rn;
      if (bus.exe_wz) bus.z <= (result == '0);
`ifdef OVF_DETECT_EN
      bus.mem_ovf   <= ovf & (state == IDLE);
`endif
    end else begin
      bus.mem_wreg  <= 1'b0;
      bus.mem_m2reg <= 1'b0;
      bus.mem_wmem  <= 1'b0;
`ifdef OVF_DETECT_EN
      bus.mem_ovf   <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed table, multiply/reset sequences, random vs model.
module tb_exe_stage;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  exe_stage_if #(.DATA_W(DATA_W)) bus ();
  exe_stage #(.DATA_W(DATA_W)) dut (.clk(clk), .clrn(clrn), .bus(bus));

  int   n_vec = 0;
  int   n_err = 0;
  logic z_m   = 1'b0;

  typedef struct {
    logic [2:0]  aluc;
    logic [31:0] a, b, imm;
    logic        shift, aluimm, wz;
    logic [31:0] exp_alu;
    logic        exp_z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] opa_of(input logic shift, input logic [31:0] a, input logic [31:0] imm);
    logic [31:0] sh;
    sh = {27'd0, imm[10:6]};
    return shift ? sh : a;
  endfunction

  function automatic logic [31:0] model_result(input logic [2:0] aluc, input logic [31:0] x, input logic [31:0] y);
    longint unsigned p;
    case (aluc)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return y << (x % 32);
      3'd6: return y >> (x % 32);
      default: begin
        p = longint'(x) * longint'(y);
        return p[31:0];
      end
    endcase
  endfunction

  function automatic logic model_ovf(input logic [2:0] aluc, input logic [31:0] x, input logic [31:0] y);
    longint s;
    if (aluc == 3'd0)      s = longint'($signed(x)) + longint'($signed(y));
    else if (aluc == 3'd1) s = longint'($signed(x)) - longint'($signed(y));
    else                   return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic drive(input logic [2:0] aluc, input logic [31:0] a, b, imm,
                       input logic shift, aluimm, wreg, m2reg, wmem, wz, input logic [4:0] rn);
    bus.exe_aluc = aluc;  bus.exe_a = a;  bus.exe_b = b;  bus.exe_imm = imm;
    bus.exe_shift = shift;  bus.exe_aluimm = aluimm;  bus.exe_wreg = wreg;
    bus.exe_m2reg = m2reg;  bus.exe_wmem = wmem;  bus.exe_wz = wz;  bus.exe_rn = rn;
  endtask

  // Present one instruction at a negedge, ride out any stall, check what it retires.
  task automatic issue(input logic [2:0] aluc, input logic [31:0] a, b, imm,
                       input logic shift, aluimm, wreg, m2reg, wmem, wz, input logic [4:0] rn,
                       input logic [31:0] exp_alu, input logic exp_z, input string tag);
    int   stalls = 0;
    int   bad = 0;
    int   exp_stalls;
    logic exp_ovf;
    drive(aluc, a, b, imm, shift, aluimm, wreg, m2reg, wmem, wz, rn);
`ifdef OVF_DETECT_EN
    exp_ovf = model_ovf(aluc, opa_of(shift, a, imm), aluimm ? imm : b);
`else
    exp_ovf = 1'b0;
`endif
    exp_stalls = (aluc == 3'd7) ? DATA_W + 1 : 0;
    #1;
    while (bus.exe_stall === 1'b1 && stalls < 100) begin
      @(posedge clk);
      @(negedge clk);
      stalls++;
      if (bus.mem_wreg !== 1'b0 || bus.mem_m2reg !== 1'b0 || bus.mem_wmem !== 1'b0 || bus.z !== z_m)
        bad++;
    end
    check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    if (stalls > 0) check({tag, " bubble_errors"}, 32'(bad), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, " mem_alu"}, bus.mem_alu, exp_alu);
    check({tag, " mem_wreg"}, {31'd0, bus.mem_wreg}, {31'd0, wreg & ~exp_ovf});
    check({tag, " mem_m2reg/wmem"}, {30'd0, bus.mem_m2reg, bus.mem_wmem}, {30'd0, m2reg, wmem});
    check({tag, " mem_b"}, bus.mem_b, b);
    check({tag, " mem_rn"}, {27'd0, bus.mem_rn}, {27'd0, rn});
    check({tag, " z"}, {31'd0, bus.z}, {31'd0, exp_z});
`ifdef OVF_DETECT_EN
    check({tag, " mem_ovf"}, {31'd0, bus.mem_ovf}, {31'd0, exp_ovf});
`endif
    z_m = exp_z;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [12];
    logic [2:0]  r_aluc;
    logic [31:0] r_a, r_b, r_imm, r_res;
    logic        r_shift, r_aluimm, r_wz;

    tbl[0]  = '{3'd0, 32'd5,          32'd3,          32'd0,          1'b0, 1'b0, 1'b0, 32'd8,          1'b0};
    tbl[1]  = '{3'd1, 32'h1234,       32'h1234,       32'd0,          1'b0, 1'b0, 1'b1, 32'd0,          1'b1};
    tbl[2]  = '{3'd3, 32'd1,          32'd0,          32'd0,          1'b0, 1'b0, 1'b0, 32'd1,          1'b1};
    tbl[3]  = '{3'd5, 32'd0,          32'h0F,         32'h100,        1'b1, 1'b0, 1'b0, 32'hF0,         1'b1};
    tbl[4]  = '{3'd6, 32'd0,          32'h0F,         32'h100,        1'b1, 1'b0, 1'b1, 32'h0,          1'b1};
    tbl[5]  = '{3'd2, 32'hF0F0,       32'h0FF0,       32'd0,          1'b0, 1'b0, 1'b1, 32'h00F0,       1'b0};
    tbl[6]  = '{3'd4, 32'hFFFF0000,   32'd0,          32'h0000FFFF,   1'b0, 1'b1, 1'b1, 32'hFFFFFFFF,   1'b0};
    tbl[7]  = '{3'd0, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1'b0, 1'b1, 32'd0,          1'b1};
    tbl[8]  = '{3'd1, 32'd0,          32'd1,          32'd0,          1'b0, 1'b0, 1'b1, 32'hFFFFFFFF,   1'b0};
    tbl[9]  = '{3'd6, 32'h24,         32'h80000000,   32'd0,          1'b0, 1'b0, 1'b0, 32'h08000000,   1'b0};
    tbl[10] = '{3'd5, 32'h21,         32'h80000001,   32'd0,          1'b0, 1'b0, 1'b0, 32'd2,          1'b0};
    tbl[11] = '{3'd0, 32'h10,         32'hDEADBEEF,   32'hFFFFFFF0,   1'b0, 1'b1, 1'b1, 32'd0,          1'b1};

    clrn = 1'b0;
    drive(3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset mem_alu", bus.mem_alu, 32'd0);
    check("reset controls", {28'd0, bus.mem_wreg, bus.mem_m2reg, bus.mem_wmem, bus.z}, 32'd0);
    check("reset mem_b/rn", bus.mem_b | {27'd0, bus.mem_rn}, 32'd0);
    check("reset exe_stall", {31'd0, bus.exe_stall}, 32'd0);
    clrn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      issue(tbl[i].aluc, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].shift, tbl[i].aluimm,
            (i != 2), iv[0], iv[1], tbl[i].wz, 5'(i + 8), tbl[i].exp_alu, tbl[i].exp_z,
            $sformatf("vec%0d", i));
    end

    // Back-to-back multiplies, including an all-ones multiplicand and a zero product.
    issue(3'd7, 32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'd42, 1'b0, "mul7x6");
    issue(3'd7, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 32'hFFFFFFFE, 1'b0, "mulFx2");
    issue(3'd7, 32'h12345678, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'd0, 1'b1, "mulx0");

`ifdef OVF_DETECT_EN
    issue(3'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h80000000, 1'b0, "ovf_add");
    issue(3'd1, 32'h80000000, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h7FFFFFFF, 1'b0, "ovf_sub");
`endif

    // Reset pulse in BUSY cycle 10 aborts the multiply.
    drive(3'd7, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6);
    for (int c = 0; c < 11; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midmul exe_stall", {31'd0, bus.exe_stall}, 32'd1);
    clrn = 1'b0;
    drive(3'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7);
    #1;
    check("abort mem_alu", bus.mem_alu, 32'd0);
    check("abort controls", {28'd0, bus.mem_wreg, bus.mem_m2reg, bus.mem_wmem, bus.z}, 32'd0);
    check("abort exe_stall", {31'd0, bus.exe_stall}, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    z_m  = 1'b0;
    issue(3'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'd3, 1'b0, "post_abort");

    for (int i = 0; i < 60; i++) begin
      r_aluc   = 3'($urandom_range(0, 7));
      r_a      = (($urandom_range(0, 7)) == 0) ? r_b : $urandom;
      r_b      = (($urandom_range(0, 7)) == 0) ? 32'd0 : $urandom;
      r_imm    = $urandom;
      r_shift  = ($urandom_range(0, 3) == 0);
      r_aluimm = ($urandom_range(0, 2) == 0);
      r_wz     = $urandom_range(0, 1) == 1;
      r_res    = model_result(r_aluc, opa_of(r_shift, r_a, r_imm), r_aluimm ? r_imm : r_b);
      issue(r_aluc, r_a, r_b, r_imm, r_shift, r_aluimm, 1'($urandom), 1'($urandom), 1'($urandom),
            r_wz, 5'($urandom), r_res, r_wz ? (r_res == 32'd0) : z_m, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
